// File: rtl/mem_bus_responder.sv
// Slave-side responder for the CPU's single-cycle memory bus: aliased word RAM,
// GPIO, a reloadable down-counter timer with interrupt, and an undecoded-access error pulse.
module mem_bus_responder #(
  parameter int          RAM_AW   = 8,
  parameter logic [15:0] IO_BASE  = 16'hFF00,
  parameter logic [15:0] ID_VALUE = 16'hC0DE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] ADDR,
  input  logic [15:0] DATA_W,
  output logic [15:0] DATA_R,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] GPIO_IN,
  output logic [15:0] GPIO_OUT,
  output logic        IRQ,
  output logic        ADDR_ERR
);

  localparam logic [7:0] OFF_GPO   = 8'd0;
  localparam logic [7:0] OFF_GPI   = 8'd1;
  localparam logic [7:0] OFF_TCNT  = 8'd2;
  localparam logic [7:0] OFF_TRLD  = 8'd3;
  localparam logic [7:0] OFF_TCTRL = 8'd4;
  localparam logic [7:0] OFF_ID    = 8'd5;
  localparam logic [7:0] OFF_FIRST_UNDECODED = 8'd6;

  // ---------------------------------------------------------------- decode
  logic [16:0]       addr_ext;
  logic              io_sel;
  logic [7:0]        io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_io;
  logic              wr_ram;

  // The I/O page may end exactly at 16'hFFFF, so the upper bound needs a 17th bit.
  assign addr_ext = {1'b0, ADDR};
  assign io_sel   = (addr_ext >= {1'b0, IO_BASE}) && (addr_ext < ({1'b0, IO_BASE} + 17'd256));
  assign io_off   = ADDR[7:0] - IO_BASE[7:0];
  assign ram_idx  = ADDR[RAM_AW-1:0];
  assign wr_io    = WR && io_sel;
  assign wr_ram   = WR && !io_sel;

  // ---------------------------------------------------------------- RAM
  logic [15:0] mem_q [2**RAM_AW];

  // NOTE: the RAM array deliberately has no reset so it maps onto a plain memory
  // macro; only the write enable sees RST, which aborts a write caught by reset.
  always_ff @(posedge CLK) begin
    if (wr_ram && !RST) begin
      mem_q[ram_idx] <= DATA_W;
    end
  end

  // ---------------------------------------------------------------- registers
  logic [15:0] gpo_q, gpo_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [15:0] treload_q, treload_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        exp_q, exp_d;
  logic        irq_q, irq_d;
  logic        err_q, err_d;
  logic [15:0] sync1_q, sync2_q;
  logic        exp_set;

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of process order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gpo_q     <= '0;
      tcnt_q    <= '0;
      treload_q <= '0;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      exp_q     <= 1'b0;
      irq_q     <= 1'b0;
      err_q     <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
    end else begin
      gpo_q     <= gpo_d;
      tcnt_q    <= tcnt_d;
      treload_q <= treload_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      exp_q     <= exp_d;
      irq_q     <= irq_d;
      err_q     <= err_d;
      sync1_q   <= GPIO_IN;
      sync2_q   <= sync1_q;
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path
  // through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    gpo_d     = gpo_q;
    tcnt_d    = tcnt_q;
    treload_d = treload_q;
    en_d      = en_q;
    ie_d      = ie_q;
    exp_d     = exp_q;
    exp_set   = 1'b0;

    if (wr_io && io_off == OFF_TCNT) begin
      tcnt_d = DATA_W;
    end else if (en_q) begin
      if (tcnt_q != 16'd0) begin
        tcnt_d = tcnt_q - 16'd1;
      end else begin
        tcnt_d  = treload_q;
        exp_set = 1'b1;
      end
    end

    if (wr_io) begin
      case (io_off)
        OFF_GPO:   gpo_d     = DATA_W;
        OFF_TRLD:  treload_d = DATA_W;
        OFF_TCTRL: begin
          en_d = DATA_W[0];
          ie_d = DATA_W[1];
          if (DATA_W[15]) exp_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Expiry beats a simultaneous write-1-to-clear.
    if (exp_set) exp_d = 1'b1;

    irq_d = exp_d && ie_d;
    err_d = (RD || WR) && io_sel && (io_off >= OFF_FIRST_UNDECODED);
  end

  // ---------------------------------------------------------------- read path
  always_comb begin
    DATA_R = 16'h0000;
    if (RD) begin
      if (io_sel) begin
        case (io_off)
          OFF_GPO:   DATA_R = gpo_q;
          OFF_GPI:   DATA_R = sync2_q;
          OFF_TCNT:  DATA_R = tcnt_q;
          OFF_TRLD:  DATA_R = treload_q;
          OFF_TCTRL: DATA_R = {exp_q, 13'd0, ie_q, en_q};
          OFF_ID:    DATA_R = ID_VALUE;
          default:   DATA_R = 16'h0000;
        endcase
      end else begin
        DATA_R = mem_q[ram_idx];
      end
    end
  end

  assign GPIO_OUT = gpo_q;
  assign IRQ      = irq_q;
  assign ADDR_ERR = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_mem_bus_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] ADDR = '0;
  logic [15:0] DATA_W = '0;
  logic [15:0] DATA_R;
  logic        RD = 1'b0;
  logic        WR = 1'b0;
  logic [15:0] GPIO_IN = '0;
  logic [15:0] GPIO_OUT;
  logic        IRQ;
  logic        ADDR_ERR;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mem_bus_responder dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .DATA_W(DATA_W), .DATA_R(DATA_R),
    .RD(RD), .WR(WR), .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT),
    .IRQ(IRQ), .ADDR_ERR(ADDR_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [15:0] gpo;
    logic [15:0] tcnt;
    logic [15:0] trl;
    logic        en;
    logic        ie;
    logic        exp;
    logic        irq;
    logic        err;
    logic [15:0] gpi_1ago;   // GPIO_IN sampled at the last edge
    logic [15:0] gpi_2ago;   // GPIO_IN sampled two edges ago (what a read sees)
  } mstate_t;

  mstate_t     m;
  logic [15:0] m_ram [256];
  bit          m_ok  [256];

  function automatic bit in_io(input logic [15:0] a);
    return (int'(a) >= 'hFF00) && (int'(a) < 'hFF00 + 256);
  endfunction

  function automatic int io_off(input logic [15:0] a);
    return int'(a) - 'hFF00;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic rd, input logic wr,
                                         input logic [15:0] a, input logic [15:0] d,
                                         input logic [15:0] g);
    mstate_t n = s;
    bit io = in_io(a);
    int off = io_off(a);
    bit fire = 1'b0;
    if (wr && io && off == 2)         n.tcnt = d;
    else if (s.en && s.tcnt != 16'd0) n.tcnt = s.tcnt - 16'd1;
    else if (s.en) begin
      n.tcnt = s.trl;
      fire   = 1'b1;
    end
    if (wr && io && off == 0) n.gpo = d;
    if (wr && io && off == 3) n.trl = d;
    if (wr && io && off == 4) begin
      n.en = d[0];
      n.ie = d[1];
      if (d[15]) n.exp = 1'b0;
    end
    if (fire) n.exp = 1'b1;
    n.irq      = n.exp & n.ie;
    n.err      = (rd || wr) && io && off >= 6;
    n.gpi_2ago = s.gpi_1ago;
    n.gpi_1ago = g;
    return n;
  endfunction

  // {known, value} of what DATA_R must show right now
  function automatic logic [16:0] model_rd(input logic rd, input logic [15:0] a);
    if (!rd) return {1'b1, 16'h0000};
    if (!in_io(a)) return {m_ok[a[7:0]], m_ram[a[7:0]]};
    case (io_off(a))
      0:       return {1'b1, m.gpo};
      1:       return {1'b1, m.gpi_2ago};
      2:       return {1'b1, m.tcnt};
      3:       return {1'b1, m.trl};
      4:       return {1'b1, m.exp, 13'd0, m.ie, m.en};
      5:       return {1'b1, 16'hC0DE};
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) m <= '0;
    else     m <= model_next(m, RD, WR, ADDR, DATA_W, GPIO_IN);
  end

  always @(posedge CLK) begin
    if (!RST && WR && !in_io(ADDR)) begin
      m_ram[ADDR[7:0]] <= DATA_W;
      m_ok[ADDR[7:0]]  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- compare
  always @(negedge CLK) begin
    if (cmp_en) begin
      logic [16:0] r;
      r = model_rd(RD, ADDR);
      if (r[16]) check("data_r", DATA_R, r[15:0]);
      check("gpio_out", GPIO_OUT, m.gpo);
      check("irq", {15'd0, IRQ}, {15'd0, m.irq});
      check("addr_err", {15'd0, ADDR_ERR}, {15'd0, m.err});
    end
  end

  // ---------------------------------------------------------------- stimulus
  // Called at posedge+1: drives one access, samples DATA_R mid-cycle, returns at next posedge+1.
  task automatic acc(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] d, output logic [15:0] dr);
    RD = rd; WR = wr; ADDR = a; DATA_W = d;
    @(negedge CLK);
    dr = DATA_R;
    @(posedge CLK);
    #1;
    RD = 1'b0; WR = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    int sel = $urandom_range(0, 9);
    if (sel < 4) return {8'($urandom_range(0, 254)), 4'h0, 4'($urandom_range(0, 15))};
    if (sel < 9) return 16'hFF00 + 16'($urandom_range(0, 7));
    return 16'hFF00 + 16'($urandom_range(8, 255));
  endfunction

  initial begin
    logic [15:0] dr;
    #2 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    cmp_en = 1'b1;

    check("rst_gpio_out", GPIO_OUT, 16'h0000);
    check("rst_irq", {15'd0, IRQ}, 16'h0000);
    acc(1, 0, 16'hFF02, 0, dr); check("rst_tcnt", dr, 16'h0000);
    acc(1, 0, 16'hFF05, 0, dr); check("id", dr, 16'hC0DE);

    // RAM aliasing
    acc(0, 1, 16'h0010, 16'hA5A5, dr);
    acc(0, 1, 16'h0110, 16'h1234, dr);
    acc(1, 0, 16'h0010, 0, dr); check("ram_alias", dr, 16'h1234);
    check("alias_no_err", {15'd0, ADDR_ERR}, 16'h0000);

    // simultaneous RD+WR
    acc(0, 1, 16'h0020, 16'h0001, dr);
    acc(1, 1, 16'h0020, 16'h0002, dr); check("rdwr_old", dr, 16'h0001);
    acc(1, 0, 16'h0020, 0, dr);        check("rdwr_new", dr, 16'h0002);

    // timer: reload 3, start from 0
    acc(0, 1, 16'hFF03, 16'h0003, dr);
    acc(0, 1, 16'hFF02, 16'h0000, dr);
    acc(0, 1, 16'hFF04, 16'h0003, dr); check("irq_not_yet", {15'd0, IRQ}, 16'h0000);
    acc(1, 0, 16'hFF02, 0, dr);        check("irq_rise", {15'd0, IRQ}, 16'h0001);
    acc(0, 1, 16'hFF04, 16'h8003, dr); check("irq_w1c", {15'd0, IRQ}, 16'h0000);
    acc(1, 0, 16'hFF02, 0, dr);        check("tcnt_2", dr, 16'h0002);
    acc(1, 0, 16'hFF02, 0, dr);        check("tcnt_1", dr, 16'h0001);
    check("irq_low", {15'd0, IRQ}, 16'h0000);
    acc(1, 0, 16'hFF02, 0, dr);        check("tcnt_0", dr, 16'h0000);
    check("irq_period", {15'd0, IRQ}, 16'h0001);
    repeat (3) acc(0, 0, 16'h0000, 0, dr);
    acc(0, 1, 16'hFF04, 16'h8003, dr); check("w1c_on_reload", {15'd0, IRQ}, 16'h0001);
    acc(0, 1, 16'hFF02, 16'h0050, dr);
    acc(1, 0, 16'hFF02, 0, dr);        check("tcnt_write_wins", dr, 16'h0050);
    acc(1, 0, 16'hFF04, 0, dr);        check("tctrl_read", dr, 16'h8003);
    acc(0, 1, 16'hFF04, 16'h0000, dr); check("irq_ie_off", {15'd0, IRQ}, 16'h0000);

    // GPIO input synchronizer, GPIO output
    GPIO_IN = 16'hBEEF;
    acc(1, 0, 16'hFF01, 0, dr); check("gpi_edge0", dr, 16'h0000);
    acc(1, 0, 16'hFF01, 0, dr); check("gpi_edge1", dr, 16'h0000);
    acc(1, 0, 16'hFF01, 0, dr); check("gpi_edge2", dr, 16'hBEEF);
    acc(0, 1, 16'hFF00, 16'h00FF, dr); check("gpio_out", GPIO_OUT, 16'h00FF);

    // undecoded I/O
    acc(1, 0, 16'hFF40, 0, dr); check("undec_data", dr, 16'h0000);
    check("addr_err_pulse", {15'd0, ADDR_ERR}, 16'h0001);
    acc(0, 0, 16'h0000, 0, dr); check("addr_err_drop", {15'd0, ADDR_ERR}, 16'h0000);

    // reset mid-count aborts a pending RAM write and keeps RAM
    acc(0, 1, 16'h0033, 16'h7777, dr);
    acc(0, 1, 16'hFF03, 16'h0005, dr);
    acc(0, 1, 16'hFF04, 16'h0003, dr);
    acc(0, 0, 16'h0000, 0, dr);
    check("pre_rst_irq", {15'd0, IRQ}, 16'h0001);
    RD = 1'b0; WR = 1'b1; ADDR = 16'h0033; DATA_W = 16'hDEAD;
    #2 RST = 1'b1;
    #1;
    check("rst_now_gpio", GPIO_OUT, 16'h0000);
    check("rst_now_irq", {15'd0, IRQ}, 16'h0000);
    @(posedge CLK);
    #1 WR = 1'b0; RD = 1'b1; ADDR = 16'hFF02;
    #1 check("rst_tcnt_read", DATA_R, 16'h0000);
    ADDR = 16'hFF04;
    #1 check("rst_tctrl_read", DATA_R, 16'h0000);
    ADDR = 16'h0033;
    #1 check("rst_ram_kept", DATA_R, 16'h7777);
    RD = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      a = rand_addr();
      ADDR   = a;
      RD     = 1'($urandom_range(0, 1));
      WR     = ($urandom_range(0, 2) == 0);
      DATA_W = 16'($urandom);
      if (a == 16'hFF02 || a == 16'hFF03) DATA_W = 16'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) GPIO_IN = 16'($urandom);
      if (i % 700 == 350) RST = 1'b1;
      if (i % 700 == 352) RST = 1'b0;
      @(posedge CLK);
      #1;
    end
    RD = 1'b0; WR = 1'b0;
    @(posedge CLK);
    #1;

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Slave-side responder for the CPU's single-cycle memory bus (ADDR, write data, RD, WR).
- Returns read data combinationally in the same cycle, because the CPU samples read data on the clock edge that ends the access.
- Contains a word-addressed RAM, memory-mapped GPIO, a reloadable down-counter timer with interrupt, and an undecoded-address error pulse.
- Sits between the CPU and the top level; replaces the testbench memory model.

Parameters:
- RAM_AW, 8, RAM address width; RAM holds 2^RAM_AW 16-bit words.
- IO_BASE, 16'hFF00, base address of the I/O page (256 words, IO_BASE..IO_BASE+255).
- ID_VALUE, 16'hC0DE, constant returned by the ID register.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- ADDR  input  16  word address from CPU.
- DATA_W  input  16  write data from CPU (CPU DATA_O).
- DATA_R  output  16  read data to CPU (CPU DATA_I); combinational.
- RD  input  1  read strobe, active high, one cycle per access.
- WR  input  1  write strobe, active high, one cycle per access.
- GPIO_IN  input  16  asynchronous external inputs.
- GPIO_OUT  output  16  registered general-purpose outputs.
- IRQ  output  1  timer interrupt, level, registered.
- ADDR_ERR  output  1  one-cycle registered pulse on access to an undecoded I/O address.

Behaviour:
- Decode:
  - ADDR >= IO_BASE and ADDR < IO_BASE+256 selects I/O.
  - Any other address selects RAM at index ADDR[RAM_AW-1:0]. Higher bits are ignored, so the RAM aliases.
- I/O map, by offset from IO_BASE:
  - 0 GPIO_OUT: R/W.
  - 1 GPIO_IN: read-only, value after the 2-flop synchronizer.
  - 2 TCNT: R/W.
  - 3 TRELOAD: R/W.
  - 4 TCTRL: bit0 EN, bit1 IE, bit15 EXP. Write data bit15 = 1 clears EXP (write-1-to-clear). Other bits read 0.
  - 5 ID: read-only ID_VALUE.
  - 6..255 undecoded.
- Read path:
  - RD=1: DATA_R is the selected location's current (pre-edge) value.
  - RD=0: DATA_R = 16'h0000.
  - Undecoded or write-only bits read 0.
- Write path: when WR=1, the selected location updates at the rising edge. Writes to read-only registers are ignored.
- RD and WR both high: the write executes. DATA_R shows the old (pre-write) value during that cycle.
- RAM:
  - Synchronous write, asynchronous read.
  - Contents are not reset; the bench must write before reading.
- Timer, evaluated each edge in priority order:
  1. A CPU write to TCNT loads DATA_W (highest priority).
  2. Otherwise, if EN=1 and TCNT != 0, TCNT decrements by 1.
  3. Otherwise, if EN=1 and TCNT == 0, TCNT loads TRELOAD and EXP sets.
  4. Otherwise TCNT holds.
  - Period is TRELOAD+1 cycles.
  - EN=0 freezes TCNT.
  - EXP set and W1C in the same cycle: set wins, EXP stays 1.
  - Writing TCTRL with EN=1 starts counting on the following edge.
- IRQ is registered: IRQ <= EXP_next & IE_next, where _next are the values these registers take at the same edge. IRQ therefore rises on the same edge EXP sets while IE=1, and falls on the edge that clears EXP or IE.
- GPIO_IN synchronizer:
  - Two flops, reset to 0.
  - A read observes an input change no earlier than 2 edges after it.
- ADDR_ERR goes high for exactly one cycle, on the edge after RD or WR is high with an undecoded I/O offset (6..255). RAM aliasing never raises ADDR_ERR.
- Reset (RST=1, asynchronous), effective immediately and held while high:
  - GPIO_OUT=0, TCNT=0, TRELOAD=0, TCTRL=0, IRQ=0, ADDR_ERR=0, sync flops=0.
  - RAM retains its contents.
  - Reset asserted mid-access aborts the write; no partial state remains.
  - DATA_R stays combinational. Under reset it reflects the reset register values, or RAM contents.

Test Plan:
- RAM: WR to 0x0010 with 16'hA5A5, then WR to 0x0110 with 16'h1234 (alias, RAM_AW=8), then RD 0x0010 -> DATA_R=16'h1234, ADDR_ERR stays 0.
- Simultaneous RD+WR: RAM[0x20]=16'h0001, then RD=WR=1 at 0x20 with DATA_W=16'h0002 -> DATA_R=16'h0001 that cycle; next RD returns 16'h0002.
- Timer period:
  - TRELOAD=3, TCNT=0, TCTRL=16'h0003 -> EXP and IRQ rise 1 edge after the enable edge.
  - They then recur every 4 cycles.
  - Writing TCTRL=16'h8003 clears IRQ on the next edge unless it coincides with a reload.
- Priority:
  - A CPU write of TCNT=16'h0050 on the same edge as a decrement -> TCNT reads 16'h0050.
  - A W1C on the reload edge -> EXP remains 1.
- GPIO and ID:
  - GPIO_IN changes to 16'hBEEF -> a read at IO_BASE+1 returns 16'hBEEF only from the 2nd edge onward.
  - Writing IO_BASE+0 with 16'h00FF -> GPIO_OUT=16'h00FF next edge.
  - Reading IO_BASE+5 -> 16'hC0DE.
- Errors and reset:
  - RD at IO_BASE+0x40 -> DATA_R=0 and a one-cycle ADDR_ERR.
  - Asserting RST mid-count -> TCNT, TCTRL, GPIO_OUT and IRQ are 0 immediately, and previously written RAM data is still readable.
